mp_grf: RTL



---
 rtl/grf_pkg.sv | 20 ++
 rtl/grf_scoreboard.sv | 45 ++++
 rtl/mp_grf.sv | 121 ++++++++++++
 3 files changed

// File: rtl/grf_pkg.sv
// Shared definitions for the multi-port general register file.
package grf_pkg;

  localparam int REG_ZERO  = 0;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int MAX_NW    = 4;

  // Highest asserted index of a match vector. Callers check the OR of the
  // vector themselves; an all-zero input returns 0.
  function automatic logic [1:0] prio_sel(input logic [MAX_NW-1:0] match);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < MAX_NW; i++) begin
      idx = match[i] ? 2'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register.
// A claim marks a register busy, a write clears it, and a claim wins
// over a write to the same register in the same cycle.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NW       = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Next scoreboard: clear on writes first, then apply the claim so it wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int w = 0; w < NW; w++) begin
      w_busy_nxt[wa[w*AW +: AW]] = we[w] ? 1'b0 : w_busy_nxt[wa[w*AW +: AW]];
    end
    w_busy_nxt[claim_addr] = claim_en ? 1'b1 : w_busy_nxt[claim_addr];
    w_busy_nxt[REG_ZERO]   = ZERO_REG ? 1'b0 : w_busy_nxt[REG_ZERO];
  end

  // Scoreboard register; reset blocks any claim or write in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/mp_grf.sv
// Parametrised multi-port general register file with optional same-cycle
// write-to-read bypass and a per-register pending scoreboard.
module mp_grf
  import grf_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NR*AW-1:0]    rd_addr,
  output logic [NR*WIDTH-1:0] rd_data,
  output logic [NR-1:0]       rd_busy,
  input  logic [NW-1:0]       we,
  input  logic [NW*AW-1:0]    wa,
  input  logic [NW*WIDTH-1:0] wd,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [DEPTH-1:0]    busy_vec
);

  logic [WIDTH-1:0]  r_mem      [DEPTH];
  logic [MAX_NW-1:0] w_we_arr;
  logic [AW-1:0]     w_wa_arr   [MAX_NW];
  logic [WIDTH-1:0]  w_wd_arr   [MAX_NW];
  logic [DEPTH-1:0]  w_wr_hit;
  logic [WIDTH-1:0]  w_wr_data  [DEPTH];
  logic [DEPTH-1:0]  w_busy_vec;

  // Unpack write ports into fixed-size arrays padded with idle ports, so the
  // priority selector always sees a full-width match vector.
  always_comb begin
    for (int w = 0; w < MAX_NW; w++) begin
      w_we_arr[w] = 1'b0;
      w_wa_arr[w] = '0;
      w_wd_arr[w] = '0;
    end
    for (int w = 0; w < NW; w++) begin
      w_we_arr[w] = we[w];
      w_wa_arr[w] = wa[w*AW +: AW];
      w_wd_arr[w] = wd[w*WIDTH +: WIDTH];
    end
  end

  // Per-register write arbitration: the highest-index matching port wins.
  always_comb begin
    logic [MAX_NW-1:0] match;
    match = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int w = 0; w < MAX_NW; w++) begin
        match[w] = w_we_arr[w] && (w_wa_arr[w] == AW'(a));
      end
      match        = (ZERO_REG && (a == REG_ZERO)) ? '0 : match;
      w_wr_hit[a]  = |match;
      w_wr_data[a] = w_wd_arr[prio_sel(match)];
    end
  end

  // Storage array; reset clears every register and suppresses writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        r_mem[a] <= '0;
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (w_wr_hit[a]) begin
          r_mem[a] <= w_wr_data[a];
        end
      end
    end
  end

  // Combinational read ports with optional same-cycle write bypass.
  // rd_busy reflects registered scoreboard state only.
  always_comb begin
    logic [AW-1:0]     addr;
    logic [MAX_NW-1:0] match;
    addr    = '0;
    match   = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NR; r++) begin
      addr = rd_addr[r*AW +: AW];
      for (int w = 0; w < MAX_NW; w++) begin
        match[w] = w_we_arr[w] && (w_wa_arr[w] == addr);
      end
      if (ZERO_REG && (addr == AW'(REG_ZERO))) begin
        rd_data[r*WIDTH +: WIDTH] = '0;
      end else if (BYPASS && (|match)) begin
        rd_data[r*WIDTH +: WIDTH] = w_wd_arr[prio_sel(match)];
      end else begin
        rd_data[r*WIDTH +: WIDTH] = r_mem[addr];
      end
      rd_busy[r] = w_busy_vec[addr];
    end
  end

  grf_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .we         (we),
    .wa         (wa),
    .busy_vec   (w_busy_vec)
  );

  assign busy_vec = w_busy_vec;

endmodule
